// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// operation encodings, FSM state encoding, iteration count and sign helpers.
package muldiv_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef logic [1:0] md_state_t;

    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_RUN  = 2'd1;
    localparam md_state_t ST_FIX  = 2'd2;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] abs_if(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    // Conditional negation used for the final sign correction.
    function automatic logic [31:0] neg_if(input logic [31:0] x, input logic neg);
        return neg ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Multiply: shift-add, one multiplier bit (in_bit, LSB first) per call.
// Divide (only with MULDIV_DIV_EN): restoring step, one dividend bit
// (in_bit, MSB first) per call; the 33-bit partial remainder lives in
// acc[32:0] and q_bit is the produced quotient bit.
module muldiv_step
    import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
    input  logic        div_mode,
    output logic        q_bit,
`endif
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    input  logic        in_bit,
    output logic [63:0] acc_next
);

    logic [32:0] sum_s;
`ifdef MULDIV_DIV_EN
    logic [32:0] shl_s;
    logic [33:0] diff_s;
`else
    // The lowest product bit is simply shifted out during multiply.
    logic unused_s;
    assign unused_s = acc[0];
`endif

    // Next accumulator/remainder for the selected mode.
    always_comb begin
        sum_s    = {1'b0, acc[63:32]} + {1'b0, (in_bit ? opnd : 32'd0)};
        acc_next = {sum_s, acc[31:1]};
`ifdef MULDIV_DIV_EN
        shl_s  = {acc[31:0], in_bit};
        diff_s = {1'b0, shl_s} - {2'b00, opnd};
        q_bit  = 1'b0;
        if (div_mode) begin
            q_bit    = ~diff_s[33];
            acc_next = {31'd0, (q_bit ? diff_s[32:0] : shl_s)};
        end else begin
            q_bit    = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// 34-cycle issue interval: capture, 32 iterations, sign fix.
// Build option: define MULDIV_DIV_EN to include the divider; without it
// divide starts are ignored and only the multiplier is present.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    md_state_t   state_r;
    logic [5:0]  cnt_r;
    logic [63:0] acc_r;
    logic [31:0] opa_r;      // multiplicand or divisor magnitude
    logic [31:0] shf_r;      // multiplier (shifts right) or dividend->quotient (shifts left)
    logic        sign_p_r;   // product / quotient sign
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic        is_signed_s;
    logic        launch_ok_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] cap_opa_s;
    logic [31:0] cap_shf_s;
    logic [63:0] acc_next_s;
    logic [31:0] shf_next_s;
    logic [63:0] prod_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;

`ifdef MULDIV_DIV_EN
    logic        is_div_r;
    logic        sign_r_r;   // remainder sign
    logic        dz_r;       // divide by zero
    logic        q_bit_s;
`endif

    // Operand magnitudes and launch qualification at capture time.
    always_comb begin
        is_signed_s = (op == MD_MULT) || (op == MD_DIV);
        abs_a_s     = abs_if(srca, is_signed_s);
        abs_b_s     = abs_if(srcb, is_signed_s);
`ifdef MULDIV_DIV_EN
        launch_ok_s = 1'b1;
        if (op[1]) begin
            cap_opa_s = abs_b_s;
            cap_shf_s = abs_a_s;
        end else begin
            cap_opa_s = abs_a_s;
            cap_shf_s = abs_b_s;
        end
`else
        launch_ok_s = ~op[1];
        cap_opa_s   = abs_a_s;
        cap_shf_s   = abs_b_s;
`endif
    end

`ifdef MULDIV_DIV_EN
    muldiv_step u_step (
        .div_mode (is_div_r),
        .q_bit    (q_bit_s),
        .acc      (acc_r),
        .opnd     (opa_r),
        .in_bit   (is_div_r ? shf_r[31] : shf_r[0]),
        .acc_next (acc_next_s)
    );
`else
    muldiv_step u_step (
        .acc      (acc_r),
        .opnd     (opa_r),
        .in_bit   (shf_r[0]),
        .acc_next (acc_next_s)
    );
`endif

    // Operand shift register: multiplier moves right, dividend left with quotient bits entering.
    always_comb begin
`ifdef MULDIV_DIV_EN
        if (is_div_r) begin
            shf_next_s = {shf_r[30:0], q_bit_s};
        end else begin
            shf_next_s = {1'b0, shf_r[31:1]};
        end
`else
        shf_next_s = {1'b0, shf_r[31:1]};
`endif
    end

    // Sign-corrected results written to HI/LO in the FIX state.
    always_comb begin
        prod_s   = sign_p_r ? (64'd0 - acc_r) : acc_r;
        fix_hi_s = prod_s[63:32];
        fix_lo_s = prod_s[31:0];
`ifdef MULDIV_DIV_EN
        if (is_div_r) begin
            fix_lo_s = dz_r ? 32'hFFFF_FFFF : neg_if(shf_r, sign_p_r);
            fix_hi_s = neg_if(acc_r[31:0], sign_r_r);
        end else begin
            fix_lo_s = prod_s[31:0];
        end
`endif
    end

    // Control FSM, iteration counter, datapath registers and HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 6'd0;
            acc_r    <= 64'd0;
            opa_r    <= 32'd0;
            shf_r    <= 32'd0;
            sign_p_r <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_r <= 1'b0;
            sign_r_r <= 1'b0;
            dz_r     <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        // start wins over a simultaneous move
                        if (launch_ok_s) begin
                            state_r  <= ST_RUN;
                            busy_r   <= 1'b1;
                            cnt_r    <= 6'd0;
                            acc_r    <= 64'd0;
                            opa_r    <= cap_opa_s;
                            shf_r    <= cap_shf_s;
                            sign_p_r <= is_signed_s & (srca[31] ^ srcb[31]);
`ifdef MULDIV_DIV_EN
                            is_div_r <= op[1];
                            sign_r_r <= is_signed_s & srca[31];
                            dz_r     <= (srcb == 32'd0);
`endif
                        end
                    end else begin
                        if (mthi) begin
                            hi_r <= srca;
                        end
                        if (mtlo) begin
                            lo_r <= srca;
                        end
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_next_s;
                    shf_r <= shf_next_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'(ITER - 1)) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    cnt_r   <= 6'd0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= 6'd0;
                end
            endcase
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    // model copy of the architectural HI/LO
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    ex_muldiv #(.ITER(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference results from the arithmetic definition of each operation.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF; eh = a;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0];
                end else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation at a negedge; returns at the sample where done is expected.
    // inj>0 drives a stray start+mthi+mtlo on that busy cycle; mv moves ride along with start.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj, input logic [1:0] mv, input string tag);
        logic [31:0] eh;
        logic [31:0] el;
        int          nb;
        bit          hold;
        model(o, a, b, eh, el);
        start = 1'b1; op = o; srca = a; srcb = b; mthi = mv[1]; mtlo = mv[0];
`ifndef MULDIV_DIV_EN
        if (o[1]) begin
            @(negedge clk);
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            chk({tag, "_nodiv_busy"}, 64'(busy), 64'd0);
            @(negedge clk);
            chk({tag, "_nodiv_done"}, 64'(done | busy), 64'd0);
            chk({tag, "_nodiv_hilo"}, {hi, lo}, {mhi, mlo});
            return;
        end
`endif
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; srca = $urandom; srcb = $urandom;
        nb = 0;
        hold = 1'b1;
        while (busy && nb < 100) begin
            nb++;
            if (hi !== mhi || lo !== mlo || done !== 1'b0) hold = 1'b0;
            if (inj > 0 && nb == inj) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = 2'($urandom_range(0, 3));
            end else if (inj > 0 && nb == inj + 1) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd33);
        chk({tag, "_hold"}, 64'(hold), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        mhi = eh;
        mlo = el;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          inj;

        rst = 1'b1; start = 1'b0; op = 2'b00; srca = 32'd0; srcb = 32'd0; mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed arithmetic cases
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 2'b00, "mult_neg3x7");
        @(negedge clk);
        chk("done_pulse_once", 64'({done, busy}), 64'd0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2'b00, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 2'b00, "div_neg7by2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2'b00, "div_ovf");
        run_op(2'b11, 32'd100, 32'd0, 0, 2'b00, "divu_by0");
        run_op(2'b01, 32'd5, 32'd9, 0, 2'b00, "multu_b2b");
        @(negedge clk);

        // moves in IDLE
        mthi = 1'b1; srca = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        mhi = 32'h1234_5678;
        chk("mthi_hi", 64'(hi), 64'(mhi));
        chk("mthi_lo", 64'(lo), 64'(mlo));
        mthi = 1'b1; mtlo = 1'b1; srca = 32'hCAFE_F00D;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        mhi = 32'hCAFE_F00D; mlo = 32'hCAFE_F00D;
        chk("mthilo_both", {hi, lo}, {mhi, mlo});

        // start with simultaneous moves: start wins, moves dropped
        run_op(2'b00, 32'd11, 32'hFFFF_FFFE, 0, 2'b11, "start_vs_move");
        // stray start/moves while busy are ignored
        run_op(2'b00, 32'h0001_0003, 32'h0002_0005, 5, 2'b00, "ignore_busy_start");
        @(negedge clk);

        // randomized operations, back to back with occasional stray requests
        for (int i = 0; i < 24; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 28)) : 0;
            run_op(ro, ra, rb, inj, 2'b00, $sformatf("rnd%0d_op%0d", i, ro));
        end
        @(negedge clk);

        // reset in the middle of an operation
        start = 1'b1; op = 2'b01; srca = 32'h7777_7777; srcb = 32'h3333_3333;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        mhi = 32'd0; mlo = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b01, 32'd123456, 32'd654321, 0, 2'b00, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
